// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.CC stopwatch: control states, BCD time layout,
// segment encoding and the BCD increment used by the counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SPLIT, STOPPED} state_e;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_BTNS   = 3;
  localparam int BTN_START  = 0;
  localparam int BTN_STOP   = 1;
  localparam int BTN_SPLIT  = 2;

  // Digit order is cc_lo, cc_hi, ss_lo, ss_hi, mm_lo, mm_hi (index 0 first).
  typedef logic [NUM_DIGITS-1:0][3:0] bcdTime_t;

  localparam bcdTime_t DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

  // Active-low segments, bit order g..a; codes 10-15 render blank.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_TABLE = {
    {6{SEG_BLANK}},
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic bcdTime_t bcdIncrement(input bcdTime_t t);
    bcdTime_t r;
    logic     carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (t[i] == DIGIT_MAX[i]) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = t[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_seg7_mux.sv
// Six-digit multiplexed 7-segment driver: scans digits 0..5, digits 6 and 7 stay dark.
// Anodes and cathodes are registered so the pins never glitch.
module seg7_mux
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  bcdTime_t              digits_i,
  input  logic [NUM_DIGITS-1:0] dpMask_i,
  output logic [7:0]            an_o,
  output logic [7:0]            decCat_o
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refCnt_q, refCnt_d;
  logic [2:0]    scanIdx_q, scanIdx_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cat_q, cat_d;

  always_comb begin
    refCnt_d  = refCnt_q + RW'(1);
    scanIdx_d = scanIdx_q;
    if (refCnt_q == REF_LAST) begin
      refCnt_d  = '0;
      scanIdx_d = (scanIdx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scanIdx_q + 3'd1;
    end
    an_d  = ~(8'h01 << scanIdx_q);
    cat_d = {~dpMask_i[scanIdx_q], SEG_TABLE[digits_i[scanIdx_q]]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refCnt_q  <= '0;
      scanIdx_q <= '0;
      an_q      <= 8'hFF;
      cat_q     <= 8'hFF;
    end else begin
      refCnt_q  <= refCnt_d;
      scanIdx_q <= scanIdx_d;
      an_q      <= an_d;
      cat_q     <= cat_d;
    end
  end

  assign an_o     = an_q;
  assign decCat_o = cat_q;

endmodule

// File: rtl/stopwatch_top.sv
// Board-level stopwatch: button synchronisers and edge detect, control FSM,
// centisecond prescaler and BCD MM:SS.CC counter feeding the display scanner.
module stopwatch_top
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV     = 1_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       split,
  output logic [7:0] an,
  output logic [7:0] dec_cat,
  output logic       running
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [NUM_BTNS-1:0]      btnLevel;
  logic [NUM_BTNS-1:0][2:0] btnSh_q;
  logic [NUM_BTNS-1:0]      btnEvt_q;
  logic                     stopEvt, startEvt, splitEvt;

  state_e        state_q, state_d;
  logic          running_q;
  logic          counting;
  logic [PW-1:0] presc_q, presc_d;
  bcdTime_t      count_q, count_d;
  bcdTime_t      frozen_q, frozen_d;
  bcdTime_t      shownTime;

  assign btnLevel = {split, stop, start};

  // Two flops resynchronise, the third holds the previous level for rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnSh_q  <= '0;
      btnEvt_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BTNS; b++) begin
        btnSh_q[b]  <= {btnSh_q[b][1:0], btnLevel[b]};
        btnEvt_q[b] <= btnSh_q[b][1] & ~btnSh_q[b][2];
      end
    end
  end

  assign stopEvt  = btnEvt_q[BTN_STOP];
  assign startEvt = btnEvt_q[BTN_START] & ~stopEvt;
  assign splitEvt = btnEvt_q[BTN_SPLIT] & ~btnEvt_q[BTN_START] & ~stopEvt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startEvt) state_d = RUN;
      RUN:     if (stopEvt) state_d = STOPPED;
               else if (splitEvt) state_d = SPLIT;
      SPLIT:   if (stopEvt) state_d = STOPPED;
               else if (splitEvt) state_d = RUN;
      STOPPED: if (stopEvt) state_d = IDLE;
               else if (startEvt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == SPLIT);

  always_comb begin
    presc_d  = presc_q;
    count_d  = count_q;
    frozen_d = frozen_q;
    if (counting) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = bcdIncrement(count_q);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if ((state_q == RUN) && splitEvt) frozen_d = count_q;
    // A second stop wipes both the time and the partial centisecond.
    if ((state_q == STOPPED) && stopEvt) begin
      count_d = '0;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      frozen_q  <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN) || (state_d == SPLIT);
      presc_q   <= presc_d;
      count_q   <= count_d;
      frozen_q  <= frozen_d;
    end
  end

  assign shownTime = (state_q == SPLIT) ? frozen_q : count_q;
  assign running   = running_q;

  seg7_mux #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_seg7_mux (
    .clk_i   (clk),
    .rst_ni  (rst),
    .digits_i(shownTime),
    .dpMask_i(DP_MASK),
    .an_o    (an),
    .decCat_o(dec_cat)
  );

endmodule

// File: tb/tb_stopwatch_top.sv
// Self-checking bench for stopwatch_top: a time-in-centiseconds model predicts the
// display pins every cycle, and directed scenarios pin hand-computed times.
module tb_stopwatch_top;

  localparam int CLK_DIV     = 4;
  localparam int REFRESH_DIV = 2;
  localparam int M_IDLE      = 0;
  localparam int M_RUN       = 1;
  localparam int M_SPLIT     = 2;
  localparam int M_STOPPED   = 3;

  logic       clk;
  logic       rst;
  logic       start, stop, split;
  logic [7:0] an, dec_cat;
  logic       running;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  logic [6:0] segLut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: time kept as total centiseconds, modulo one hour.
  int         mState, mCount, mFrozen, mPresc, mRef, mScan, mShown, oldCount;
  int         mDig [6];
  bit [3:0]   hStart, hStop, hSplit;
  bit         eStop, eStartRaw, eStart, eSplit;
  logic [7:0] expAn, expCat;
  logic       expRun;
  bit         preloadReq = 0;
  int         preloadVal = 0;

  stopwatch_top #(
    .CLK_DIV    (CLK_DIV),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .split  (split),
    .an     (an),
    .dec_cat(dec_cat),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mState = M_IDLE; mCount = 0; mFrozen = 0; mPresc = 0; mRef = 0; mScan = 0;
      hStart = '0; hStop = '0; hSplit = '0;
      expAn = 8'hFF; expCat = 8'hFF; expRun = 1'b0;
    end else begin
      if (preloadReq) mCount = preloadVal;
      mShown  = (mState == M_SPLIT) ? mFrozen : mCount;
      mDig[0] = (mShown % 100) % 10;
      mDig[1] = (mShown % 100) / 10;
      mDig[2] = ((mShown / 100) % 60) % 10;
      mDig[3] = ((mShown / 100) % 60) / 10;
      mDig[4] = (mShown / 6000) % 10;
      mDig[5] = (mShown / 6000) / 10;
      expAn  = ~(8'h01 << mScan);
      expCat = {(mScan == 2 || mScan == 4) ? 1'b0 : 1'b1, segLut[mDig[mScan]]};
      if (mRef == REFRESH_DIV - 1) begin
        mRef  = 0;
        mScan = (mScan + 1) % 6;
      end else begin
        mRef++;
      end
      // A press is seen by the control logic three clocks after its level is first sampled.
      eStop     = hStop[2] & ~hStop[3];
      eStartRaw = hStart[2] & ~hStart[3];
      eStart    = eStartRaw & ~eStop;
      eSplit    = hSplit[2] & ~hSplit[3] & ~eStartRaw & ~eStop;
      oldCount  = mCount;
      if (mState == M_RUN || mState == M_SPLIT) begin
        if (mPresc == CLK_DIV - 1) begin
          mPresc = 0;
          mCount = (mCount + 1) % 360000;
        end else begin
          mPresc++;
        end
      end
      case (mState)
        M_IDLE:    if (eStart) mState = M_RUN;
        M_RUN:     if (eStop) mState = M_STOPPED;
                   else if (eSplit) begin mState = M_SPLIT; mFrozen = oldCount; end
        M_SPLIT:   if (eStop) mState = M_STOPPED;
                   else if (eSplit) mState = M_RUN;
        default:   if (eStop) begin mState = M_IDLE; mCount = 0; mPresc = 0; end
                   else if (eStart) mState = M_RUN;
      endcase
      expRun = (mState == M_RUN || mState == M_SPLIT);
      hStart = {hStart[2:0], start};
      hStop  = {hStop[2:0], stop};
      hSplit = {hSplit[2:0], split};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("an vs model", an, expAn);
        checkOutput("dec_cat vs model", dec_cat, expCat);
        checkOutput("running vs model", running, expRun);
      end
    end
  endtask

  // Levels change at a negedge; returns the posedge index that first samples them.
  task automatic applyStimulus(input bit s, input bit t, input bit sp, input int hold,
                               output int sampleEdge);
    sampleEdge = cyc + 1;
    start = s; stop = t; split = sp;
    repeat (hold) @(negedge clk);
    start = 1'b0; stop = 1'b0; split = 1'b0;
  endtask

  task automatic waitEdge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  function automatic int decodeSeg(input logic [6:0] seg);
    for (int i = 0; i < 10; i++) if (seg == segLut[i]) return i;
    return -1;
  endfunction

  // Reads a static display off the pins as a decimal MMSSCC number; -1 if unreadable.
  task automatic captureDisplay(output int value);
    int dig [6];
    bit [5:0] seen;
    bit bad;
    seen = '0;
    bad  = 1'b0;
    for (int i = 0; i < 6; i++) dig[i] = 0;
    for (int n = 0; n < 20 && seen != 6'h3F; n++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (an == ~(8'h01 << i)) begin
          dig[i]  = decodeSeg(dec_cat[6:0]);
          seen[i] = 1'b1;
          if (dig[i] < 0) bad = 1'b1;
        end
      end
    end
    if (seen != 6'h3F || bad) value = -1;
    else value = dig[5] * 100000 + dig[4] * 10000 + dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
  endtask

  initial begin
    int v;
    int p;
    rst = 1'b0; start = 1'b0; stop = 1'b0; split = 1'b0;
    fork compareLoop(); join_none
    repeat (3) @(negedge clk);
    checkOutput("reset an", an, 8'hFF);
    checkOutput("reset dec_cat", dec_cat, 8'hFF);
    checkOutput("reset running", running, 1'b0);
    rst = 1'b1;
    captureDisplay(v);
    checkOutput("idle display", v, 0);

    // First tick lands 7 edges after start is sampled, then every 4; stop sampled at +44 still
    // lets the tick at +47 through, giving 11 centiseconds.
    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 10);
    checkOutput("running after start", running, 1'b1);
    waitEdge(p + 44);
    applyStimulus(0, 1, 0, 2, p);
    waitEdge(p + 8);
    captureDisplay(v);
    checkOutput("stopped display", v, 11);
    checkOutput("model stopped count", mCount, 11);
    checkOutput("running after stop", running, 1'b0);

    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 44);
    applyStimulus(0, 1, 0, 2, p);
    waitEdge(p + 8);
    captureDisplay(v);
    checkOutput("resumed display", v, 22);

    applyStimulus(0, 1, 0, 2, p);
    waitEdge(p + 6);
    captureDisplay(v);
    checkOutput("cleared display", v, 0);
    checkOutput("running after clear", running, 1'b0);

    // Split at +20 freezes the value before the +23 tick (4); stop at +100 yields 25 ticks.
    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 20);
    applyStimulus(0, 0, 1, 2, v);
    waitEdge(p + 26);
    captureDisplay(v);
    checkOutput("split frozen display", v, 4);
    checkOutput("model frozen value", mFrozen, 4);
    checkOutput("running in split", running, 1'b1);
    waitEdge(p + 60);
    applyStimulus(0, 0, 1, 2, v);
    waitEdge(p + 100);
    applyStimulus(0, 1, 0, 2, v);
    waitEdge(p + 108);
    captureDisplay(v);
    checkOutput("count kept running in split", v, 25);
    applyStimulus(0, 1, 0, 2, p);
    waitEdge(p + 6);

    preloadVal = 359999;
    preloadReq = 1'b1;
    force dut.count_q = 24'h595999;
    @(negedge clk);
    release dut.count_q;
    preloadReq = 1'b0;
    captureDisplay(v);
    checkOutput("preload display", v, 595999);
    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 8);
    checkOutput("model wrapped to zero", mCount, 0);
    checkOutput("running after wrap", running, 1'b1);
    applyStimulus(0, 1, 0, 2, v);
    waitEdge(p + 16);
    captureDisplay(v);
    checkOutput("after wrap display", v, 1);

    preloadVal = 5998;
    preloadReq = 1'b1;
    force dut.count_q = 24'h005998;
    @(negedge clk);
    release dut.count_q;
    preloadReq = 1'b0;
    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 8);
    applyStimulus(0, 1, 0, 2, v);
    waitEdge(p + 16);
    captureDisplay(v);
    checkOutput("cc and ss carry display", v, 10000);

    // Start and stop together, held 20 clocks: one stop event, so STOPPED rather than cleared.
    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 12);
    applyStimulus(1, 1, 0, 20, v);
    waitEdge(p + 40);
    captureDisplay(v);
    checkOutput("held start+stop display", v, 10003);
    checkOutput("running after start+stop", running, 1'b0);

    applyStimulus(1, 0, 0, 2, p);
    waitEdge(p + 20);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid-count reset an", an, 8'hFF);
    checkOutput("mid-count reset dec_cat", dec_cat, 8'hFF);
    checkOutput("mid-count reset running", running, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    captureDisplay(v);
    checkOutput("display after mid-count reset", v, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
